adc_led_meter: RTL and testbench

- Parametrised successor to the static ADC-bits-to-LED debug mapping.
- Drives an LED_COUNT bar with one of two selectable displays:
  - mode 0: raw top bits of the ADC word.
  - mode 1: windowed peak-level bar graph, about 6 dB per LED, with a peak-hold dot, hold/decay timing and a stretched overrange indicator.
- Sits on the ADC sample clock domain, directly after the ADC input pins, and feeds board debug LEDs.

---
 rtl/adc_led_meter.sv | 176 +++++++++++++++++
 tb/tb_adc_led_meter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/adc_led_meter.sv
// ADC debug LED driver: raw top bits (mode 0) or windowed peak bar meter (mode 1).
// Optional macro ADC_LED_METER_OFFSET_BIN_EN treats adc_data as offset binary.
module adc_led_meter #(
  parameter int ADC_WIDTH        = 12,
  parameter int LED_COUNT        = 8,
  parameter int WINDOW_LOG2      = 16,
  parameter int HOLD_WINDOWS     = 8,
  parameter int OTR_HOLD_WINDOWS = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sample_en,
  input  logic [ADC_WIDTH-1:0]             adc_data,
  input  logic                             adc_otr,
  input  logic                             mode,
  output logic [LED_COUNT-1:0]             leds,
  output logic                             ovr_led,
  output logic [$clog2(LED_COUNT+1)-1:0]   level,
  output logic                             window_done
);

  localparam int MAG_W = ADC_WIDTH - 1;
  localparam int LVL_W = $clog2(LED_COUNT + 1);
  localparam int HC_W  = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
  localparam int OC_W  = (OTR_HOLD_WINDOWS > 0) ? $clog2(OTR_HOLD_WINDOWS + 1) : 1;

  // Each lit LED is one bit of magnitude (~6 dB); the lowest LED is bit MAG_W-LED_COUNT.
  function automatic logic [LVL_W-1:0] litOf(input logic [MAG_W-1:0] m);
    int bl;
    bl = 0;
    for (int i = 0; i < MAG_W; i++) begin
      if (m[i]) bl = i + 1;
    end
    bl = bl - (MAG_W - LED_COUNT);
    if (bl < 0) bl = 0;
    if (bl > LED_COUNT) bl = LED_COUNT;
    return LVL_W'(bl);
  endfunction

  logic [ADC_WIDTH-1:0]   s1_data_q, s1_data_d, s1_in, neg;
  logic                   s1_otr_q, s1_otr_d, s1_vld_q, s1_vld_d;
  logic [MAG_W-1:0]       mag_q, mag_d, win_max_q, win_max_d, peak;
  logic                   s2_otr_q, s2_otr_d, s2_vld_q, s2_vld_d;
  logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic                   otr_lat_q, otr_lat_d;
  logic                   close_q, close_d, close_otr_q, close_otr_d;
  logic [LVL_W-1:0]       level_q, level_d, hold_lvl_q, hold_lvl_d;
  logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [OC_W-1:0]        ovr_cnt_q, ovr_cnt_d;
  logic                   ovr_q, ovr_d, done_q, done_d;
  logic [LED_COUNT-1:0]   raw_q, raw_d, meter_q, meter_d, leds_q, leds_d, bar, dot;

  always_comb begin
    s1_in = adc_data;
`ifdef ADC_LED_METER_OFFSET_BIN_EN
    s1_in[ADC_WIDTH-1] = ~adc_data[ADC_WIDTH-1];
`else
`endif
    s1_data_d   = sample_en ? s1_in : s1_data_q;
    s1_otr_d    = sample_en ? adc_otr : s1_otr_q;
    s1_vld_d    = sample_en;

    // Stage 2: magnitude, with the most negative code saturating to full scale.
    neg = '0 - s1_data_q;
    if (s1_data_q == {1'b1, {(ADC_WIDTH-1){1'b0}}}) mag_d = '1;
    else if (s1_data_q[ADC_WIDTH-1])                 mag_d = neg[MAG_W-1:0];
    else                                             mag_d = s1_data_q[MAG_W-1:0];
    s2_otr_d = s1_otr_q;
    s2_vld_d = s1_vld_q;

    peak        = (mag_q > win_max_q) ? mag_q : win_max_q;
    win_cnt_d   = win_cnt_q;
    win_max_d   = win_max_q;
    otr_lat_d   = otr_lat_q;
    close_d     = 1'b0;
    close_otr_d = close_otr_q;
    level_d     = level_q;
    if (s2_vld_q) begin
      win_cnt_d = win_cnt_q + WINDOW_LOG2'(1);
      if (win_cnt_q == '1) begin
        close_d     = 1'b1;
        close_otr_d = otr_lat_q | s2_otr_q;
        level_d     = litOf(peak);
        win_max_d   = '0;
        otr_lat_d   = 1'b0;
      end else begin
        win_max_d   = peak;
        otr_lat_d   = otr_lat_q | s2_otr_q;
      end
    end
    done_d = close_d;

    // Window-rate hold/decay and overrange stretch, one step per closed window.
    hold_lvl_d = hold_lvl_q;
    hold_cnt_d = hold_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    ovr_d      = ovr_q;
    if (close_q) begin
      if (level_q >= hold_lvl_q) begin
        hold_lvl_d = level_q;
        hold_cnt_d = HC_W'(HOLD_WINDOWS);
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HC_W'(1);
      end else if (hold_lvl_q != '0) begin
        hold_lvl_d = hold_lvl_q - LVL_W'(1);
      end
      if (close_otr_q) begin
        ovr_cnt_d = OC_W'(OTR_HOLD_WINDOWS);
        ovr_d     = 1'b1;
      end else if (ovr_cnt_q != '0) begin
        ovr_cnt_d = ovr_cnt_q - OC_W'(1);
        ovr_d     = (ovr_cnt_d != '0);
      end
    end

    for (int i = 0; i < LED_COUNT; i++) begin
      bar[i] = (i < int'(level_q));
      dot[i] = (int'(hold_lvl_d) == i + 1);
    end
    meter_d = close_q ? (bar | dot) : meter_q;
    raw_d   = s1_vld_q ? s1_data_q[ADC_WIDTH-1 -: LED_COUNT] : raw_q;
    leds_d  = mode ? meter_d : raw_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q   <= '0;
      s1_otr_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      mag_q       <= '0;
      s2_otr_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      win_cnt_q   <= '0;
      win_max_q   <= '0;
      otr_lat_q   <= 1'b0;
      close_q     <= 1'b0;
      close_otr_q <= 1'b0;
      level_q     <= '0;
      done_q      <= 1'b0;
      hold_lvl_q  <= '0;
      hold_cnt_q  <= '0;
      ovr_cnt_q   <= '0;
      ovr_q       <= 1'b0;
      raw_q       <= '0;
      meter_q     <= '0;
      leds_q      <= '0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_otr_q    <= s1_otr_d;
      s1_vld_q    <= s1_vld_d;
      mag_q       <= mag_d;
      s2_otr_q    <= s2_otr_d;
      s2_vld_q    <= s2_vld_d;
      win_cnt_q   <= win_cnt_d;
      win_max_q   <= win_max_d;
      otr_lat_q   <= otr_lat_d;
      close_q     <= close_d;
      close_otr_q <= close_otr_d;
      level_q     <= level_d;
      done_q      <= done_d;
      hold_lvl_q  <= hold_lvl_d;
      hold_cnt_q  <= hold_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      ovr_q       <= ovr_d;
      raw_q       <= raw_d;
      meter_q     <= meter_d;
      leds_q      <= leds_d;
    end
  end

  assign leds        = leds_q;
  assign ovr_led     = ovr_q;
  assign level       = level_q;
  assign window_done = done_q;

endmodule

// File: tb/tb_adc_led_meter.sv
// Directed bench for adc_led_meter with 4-sample windows and short hold/overrange timers.
module tb_adc_led_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_en;
  logic [11:0] adc_data;
  logic        adc_otr;
  logic        mode;
  logic [7:0]  leds;
  logic        ovr_led;
  logic [3:0]  level;
  logic        window_done;
  int          checks = 0;
  int          passed = 0;

  adc_led_meter #(
    .ADC_WIDTH(12), .LED_COUNT(8), .WINDOW_LOG2(2), .HOLD_WINDOWS(2), .OTR_HOLD_WINDOWS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .adc_data(adc_data),
    .adc_otr(adc_otr), .mode(mode), .leds(leds), .ovr_led(ovr_led), .level(level),
    .window_done(window_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int value, input logic otr);
    @(negedge clk);
    sample_en = 1'b1;
    adc_data  = 12'(value);
    adc_otr   = otr;
  endtask

  // Feeds one full window back to back, then checks the k+2 and k+3 results of its close.
  task automatic runWindow(input string tag, input int a, input int b, input int c, input int d,
                           input int otrPos, input logic [3:0] expLevel,
                           input logic [7:0] expLeds, input logic expOvr);
    applyStimulus(a, otrPos == 0);
    applyStimulus(b, otrPos == 1);
    applyStimulus(c, otrPos == 2);
    applyStimulus(d, otrPos == 3);
    @(negedge clk);
    sample_en = 1'b0;
    adc_otr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_done"}, 16'(window_done), 16'd1);
    checkOutput({tag, "_level"}, 16'(level), 16'(expLevel));
    @(negedge clk);
    checkOutput({tag, "_leds"}, 16'(leds), 16'(expLeds));
    checkOutput({tag, "_ovr"}, 16'(ovr_led), 16'(expOvr));
    checkOutput({tag, "_done_low"}, 16'(window_done), 16'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    sample_en = 1'b0;
    adc_data  = '0;
    adc_otr   = 1'b0;
    mode      = 1'b0;
    #1;
    checkOutput("rst_leds", 16'(leds), 16'd0);
    checkOutput("rst_ovr", 16'(ovr_led), 16'd0);
    checkOutput("rst_level", 16'(level), 16'd0);
    checkOutput("rst_done", 16'(window_done), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(12'hA5C, 1'b0);
    @(negedge clk);
    sample_en = 1'b0;
    checkOutput("raw_latency", 16'(leds), 16'd0);
    @(negedge clk);
    checkOutput("raw_leds", 16'(leds), 16'hA5);
    mode = 1'b1;
    @(negedge clk);
    checkOutput("switch_to_meter", 16'(leds), 16'd0);
    mode = 1'b0;
    @(negedge clk);
    checkOutput("switch_to_raw", 16'(leds), 16'hA5);

    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mode    = 1'b1;
    @(negedge clk);
    checkOutput("rst2_leds", 16'(leds), 16'd0);

    runWindow("bar", 100, -300, 50, 20, -1, 4'd6, 8'b0011_1111, 1'b0);
    runWindow("decay1", 0, 0, 0, 0, -1, 4'd0, 8'b0010_0000, 1'b0);
    runWindow("decay2", 0, 0, 0, 0, -1, 4'd0, 8'b0010_0000, 1'b0);
    runWindow("decay3", 0, 0, 0, 0, -1, 4'd0, 8'b0001_0000, 1'b0);
    runWindow("decay4", 0, 0, 0, 0, -1, 4'd0, 8'b0000_1000, 1'b0);
    runWindow("sat", -2048, 0, 0, 0, -1, 4'd8, 8'hFF, 1'b0);
    runWindow("ovrW", 0, 0, 0, 0, 1, 4'd0, 8'h80, 1'b1);
    runWindow("ovrW1", 0, 0, 0, 0, -1, 4'd0, 8'h80, 1'b1);
    runWindow("ovrW2", 0, 0, 0, 0, -1, 4'd0, 8'h40, 1'b1);
    runWindow("ovrW3", 0, 0, 0, 0, -1, 4'd0, 8'h20, 1'b0);

    applyStimulus(2000, 1'b0);
    applyStimulus(2000, 1'b0);
    @(negedge clk);
    sample_en = 1'b0;
    reset_n   = 1'b0;
    #1;
    checkOutput("midrst_leds", 16'(leds), 16'd0);
    checkOutput("midrst_level", 16'(level), 16'd0);
    checkOutput("midrst_ovr", 16'(ovr_led), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    runWindow("after_rst", 10, 10, 10, 10, -1, 4'd1, 8'b0000_0001, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
